// File: rtl/bt_arq_pkg.sv
// Shared constants for the ACL ARQ/SEQN/FLOW sequencer: packet-type classes,
// ARQN polarity and the receive-window FSM encoding.
package bt_arq_pkg;

  // TYPE codes whose payload carries a CRC: DM1, DH1, DM3, DH3, DM5, DH5
  localparam logic [15:0] CRC_PKT_MASK = 16'hCC18;
  localparam logic        ARQ_ACK      = 1'b1;
  localparam logic [3:0]  TYPE_NULL    = 4'd0;
  localparam logic [3:0]  TYPE_POLL    = 4'd1;

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_RX_HDR = 2'd1;
  localparam logic [1:0]  ST_RX_PY  = 2'd2;
  localparam logic [1:0]  ST_UPDATE = 2'd3;

  function automatic logic pkt_has_crc(input logic [3:0] pk_type);
    return CRC_PKT_MASK[pk_type];
  endfunction

endpackage

// File: rtl/arq_seqn_ctrl.sv
// Per-LT_ADDR ARQ/SEQN/FLOW sequencer: follows each rx slot (header then payload
// CRC) and maintains the SEQN/ARQN/FLOW bits and retransmit requests for tx.
module arq_seqn_ctrl
  import bt_arq_pkg::*;
#(
  parameter logic [3:0] MAX_RETX = 4'd15
) (
  input  logic       clk_6M,
  input  logic       rstz,
  input  logic       p_1us,
  input  logic       ms_tslot_p,
  input  logic       rx_trailer_st_p,
  input  logic       hdr_done_p,
  input  logic       dec_hecgood,
  input  logic [2:0] dec_lt_addr,
  input  logic [3:0] dec_pk_type,
  input  logic       dec_seqn,
  input  logic       dec_arqn_bit,
  input  logic       crc_done_p,
  input  logic       crcgood,
  input  logic       rxbuf_full,
  input  logic       tx_packet_st_p,
  input  logic [2:0] tx_lt_addr,
  input  logic [3:0] tx_pk_type,
  output logic [7:0] txaclSEQN,
  output logic [7:0] txARQN,
  output logic       rspFLOW,
  output logic [7:0] tx_retx,
  output logic       tx_ack_p,
  output logic [2:0] ack_lt,
  output logic       rx_accept_p,
  output logic       rx_dup_p,
  output logic [1:0] fsm_st
);

  logic [1:0]      st;
  logic [2:0]      rx_lt;
  logic            rx_seqn;
  logic            crc_ok;
  logic [7:0]      seqn_old;
  logic [7:0]      tx_has_crc;
  logic [7:0][3:0] retx_cnt;

  logic [3:0] cnt_cur;
  logic [3:0] cnt_inc;
  logic       hdr_ack;
  logic       flush;
  logic       rel_tx;

  assign fsm_st = st;

  // A NAK that reaches MAX_RETX releases the held payload exactly like an ACK.
  always_comb begin
    cnt_cur = retx_cnt[dec_lt_addr];
    cnt_inc = (cnt_cur == 4'hF) ? cnt_cur : cnt_cur + 4'd1;
    hdr_ack = (dec_arqn_bit == ARQ_ACK);
    flush   = !hdr_ack && (MAX_RETX != 4'd0) && (cnt_inc >= MAX_RETX);
    rel_tx  = (hdr_ack && tx_has_crc[dec_lt_addr]) || flush;
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      st          <= ST_IDLE;
      rx_lt       <= 3'd0;
      rx_seqn     <= 1'b0;
      crc_ok      <= 1'b0;
      seqn_old    <= 8'hFF;
      tx_has_crc  <= 8'h00;
      retx_cnt    <= '0;
      txaclSEQN   <= 8'h00;
      txARQN      <= 8'h00;
      rspFLOW     <= 1'b1;
      tx_retx     <= 8'h00;
      tx_ack_p    <= 1'b0;
      ack_lt      <= 3'd0;
      rx_accept_p <= 1'b0;
      rx_dup_p    <= 1'b0;
    end else begin
      tx_ack_p    <= 1'b0;
      rx_accept_p <= 1'b0;
      rx_dup_p    <= 1'b0;
      if (p_1us)
        rspFLOW <= !rxbuf_full;
      if (tx_packet_st_p && p_1us)
        tx_has_crc[tx_lt_addr] <= pkt_has_crc(tx_pk_type);

      case (st)
        ST_IDLE: begin
          if (rx_trailer_st_p && p_1us)
            st <= ST_RX_HDR;
        end
        ST_RX_HDR: begin
          if (hdr_done_p) begin
            st <= ST_IDLE;
            if (dec_hecgood) begin
              if (rel_tx) begin
                if (tx_has_crc[dec_lt_addr])
                  txaclSEQN[dec_lt_addr] <= ~txaclSEQN[dec_lt_addr];
                tx_retx[dec_lt_addr]  <= 1'b0;
                retx_cnt[dec_lt_addr] <= 4'd0;
                tx_ack_p              <= 1'b1;
                ack_lt                <= dec_lt_addr;
              end else if (!hdr_ack) begin
                tx_retx[dec_lt_addr]  <= 1'b1;
                retx_cnt[dec_lt_addr] <= cnt_inc;
              end
              if (pkt_has_crc(dec_pk_type)) begin
                st      <= ST_RX_PY;
                rx_lt   <= dec_lt_addr;
                rx_seqn <= dec_seqn;
              end
            end
          end else if (ms_tslot_p) begin
            st <= ST_IDLE;
          end
        end
        ST_RX_PY: begin
          if (crc_done_p) begin
            crc_ok <= crcgood;
            st     <= ST_UPDATE;
          end else if (ms_tslot_p) begin
            txARQN[rx_lt] <= 1'b0;
            st            <= ST_IDLE;
          end
        end
        default: begin
          // Duplicate check comes first so a repeated SEQN is always re-ACKed.
          if (rx_seqn == seqn_old[rx_lt]) begin
            txARQN[rx_lt] <= 1'b1;
            rx_dup_p      <= 1'b1;
          end else if (crc_ok && !rxbuf_full) begin
            txARQN[rx_lt]   <= 1'b1;
            seqn_old[rx_lt] <= rx_seqn;
            rx_accept_p     <= 1'b1;
          end else begin
            txARQN[rx_lt] <= 1'b0;
          end
          st <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arq_seqn_ctrl.sv
// Directed plus randomized bench for arq_seqn_ctrl against a per-packet
// reference model of the ARQ/SEQN rules.
module tb_arq_seqn_ctrl;
  import bt_arq_pkg::*;

  localparam int MAXR = 2;

  logic       clk_6M = 1'b0;
  logic       rstz = 1'b0;
  logic       p_1us;
  logic       ms_tslot_p = 1'b0;
  logic       rx_trailer_st_p = 1'b0;
  logic       hdr_done_p = 1'b0;
  logic       dec_hecgood = 1'b0;
  logic [2:0] dec_lt_addr = 3'd0;
  logic [3:0] dec_pk_type = 4'd0;
  logic       dec_seqn = 1'b0;
  logic       dec_arqn_bit = 1'b0;
  logic       crc_done_p = 1'b0;
  logic       crcgood = 1'b0;
  logic       rxbuf_full = 1'b0;
  logic       tx_packet_st_p = 1'b0;
  logic [2:0] tx_lt_addr = 3'd0;
  logic [3:0] tx_pk_type = 4'd0;
  logic [7:0] txaclSEQN;
  logic [7:0] txARQN;
  logic       rspFLOW;
  logic [7:0] tx_retx;
  logic       tx_ack_p;
  logic [2:0] ack_lt;
  logic       rx_accept_p;
  logic       rx_dup_p;
  logic [1:0] fsm_st;

  arq_seqn_ctrl #(.MAX_RETX(4'(MAXR))) dut (
    .clk_6M(clk_6M), .rstz(rstz), .p_1us(p_1us), .ms_tslot_p(ms_tslot_p),
    .rx_trailer_st_p(rx_trailer_st_p), .hdr_done_p(hdr_done_p),
    .dec_hecgood(dec_hecgood), .dec_lt_addr(dec_lt_addr), .dec_pk_type(dec_pk_type),
    .dec_seqn(dec_seqn), .dec_arqn_bit(dec_arqn_bit), .crc_done_p(crc_done_p),
    .crcgood(crcgood), .rxbuf_full(rxbuf_full), .tx_packet_st_p(tx_packet_st_p),
    .tx_lt_addr(tx_lt_addr), .tx_pk_type(tx_pk_type), .txaclSEQN(txaclSEQN),
    .txARQN(txARQN), .rspFLOW(rspFLOW), .tx_retx(tx_retx), .tx_ack_p(tx_ack_p),
    .ack_lt(ack_lt), .rx_accept_p(rx_accept_p), .rx_dup_p(rx_dup_p), .fsm_st(fsm_st)
  );

  // clock / strobe
  always #83 clk_6M = ~clk_6M;
  int cyc = 0;
  always @(posedge clk_6M) cyc <= cyc + 1;
  assign p_1us = (cyc % 6 == 5);

  // pulse monitor
  int acc_n = 0, dup_n = 0, ack_n = 0;
  logic [2:0] ack_lt_seen = 3'd0;
  always @(negedge clk_6M) begin
    if (rx_accept_p) acc_n++;
    if (rx_dup_p) dup_n++;
    if (tx_ack_p) begin ack_n++; ack_lt_seen = ack_lt; end
  end

  // reference model
  logic [7:0] m_seq, m_arqn, m_retx, m_has, m_old;
  int m_cnt [8];
  int checks = 0, failures = 0;

  function automatic logic is_crc_type(input logic [3:0] t);
    return (t == 4'd3 || t == 4'd4 || t == 4'd10 || t == 4'd11 || t == 4'd14 || t == 4'd15);
  endfunction

  task automatic model_reset();
    m_seq = 8'h00; m_arqn = 8'h00; m_retx = 8'h00; m_has = 8'h00; m_old = 8'hFF;
    for (int i = 0; i < 8; i++) m_cnt[i] = 0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe();
    int n = 0;
    do begin @(negedge clk_6M); n++; end while (!p_1us && n < 20);
  endtask

  task automatic tx_pkt(input logic [2:0] lt, input logic [3:0] pt);
    wait_strobe();
    tx_packet_st_p = 1'b1; tx_lt_addr = lt; tx_pk_type = pt;
    @(negedge clk_6M);
    tx_packet_st_p = 1'b0;
    m_has[lt] = is_crc_type(pt);
  endtask

  task automatic rx_pkt(input string tag, input logic [2:0] lt, input logic [3:0] pt,
                        input logic sq, input logic aq, input logic hec,
                        input logic crc, input logic bf, input logic early);
    int a0 = acc_n, d0 = dup_n, k0 = ack_n;
    int ea = 0, ed = 0, ek = 0;
    if (hec) begin
      if (aq) begin
        if (m_has[lt]) begin m_seq[lt] = ~m_seq[lt]; m_retx[lt] = 0; m_cnt[lt] = 0; ek = 1; end
      end else begin
        m_cnt[lt] = (m_cnt[lt] == 15) ? 15 : m_cnt[lt] + 1;
        if (MAXR != 0 && m_cnt[lt] >= MAXR) begin
          if (m_has[lt]) m_seq[lt] = ~m_seq[lt];
          m_retx[lt] = 0; m_cnt[lt] = 0; ek = 1;
        end else m_retx[lt] = 1;
      end
      if (is_crc_type(pt)) begin
        if (early) m_arqn[lt] = 0;
        else if (sq == m_old[lt]) begin m_arqn[lt] = 1; ed = 1; end
        else if (crc && !bf) begin m_arqn[lt] = 1; m_old[lt] = sq; ea = 1; end
        else m_arqn[lt] = 0;
      end
    end
    rxbuf_full = bf;
    wait_strobe();
    rx_trailer_st_p = 1'b1;
    @(negedge clk_6M);
    rx_trailer_st_p = 1'b0;
    repeat (2) @(negedge clk_6M);
    dec_lt_addr = lt; dec_pk_type = pt; dec_seqn = sq; dec_arqn_bit = aq; dec_hecgood = hec;
    hdr_done_p = 1'b1;
    @(negedge clk_6M);
    hdr_done_p = 1'b0;
    if (hec && is_crc_type(pt)) begin
      repeat (2) @(negedge clk_6M);
      if (early) ms_tslot_p = 1'b1;
      else begin crc_done_p = 1'b1; crcgood = crc; end
      @(negedge clk_6M);
      ms_tslot_p = 1'b0; crc_done_p = 1'b0;
    end
    repeat (3) @(negedge clk_6M);
    chk({tag, ".txARQN"}, txARQN, m_arqn);
    chk({tag, ".txaclSEQN"}, txaclSEQN, m_seq);
    chk({tag, ".tx_retx"}, tx_retx, m_retx);
    chk({tag, ".accept"}, 8'(acc_n - a0), 8'(ea));
    chk({tag, ".dup"}, 8'(dup_n - d0), 8'(ed));
    chk({tag, ".ack"}, 8'(ack_n - k0), 8'(ek));
    if (ek != 0) chk({tag, ".ack_lt"}, 8'(ack_lt_seen), 8'(lt));
    chk({tag, ".idle"}, 8'(fsm_st), 8'(ST_IDLE));
  endtask

  initial begin
    int a0, d0, k0;
    model_reset();
    repeat (3) @(negedge clk_6M);
    chk("rst.txARQN", txARQN, 8'h00);
    chk("rst.txaclSEQN", txaclSEQN, 8'h00);
    chk("rst.tx_retx", tx_retx, 8'h00);
    chk("rst.rspFLOW", 8'(rspFLOW), 8'h01);
    chk("rst.fsm", 8'(fsm_st), 8'(ST_IDLE));
    rstz = 1'b1;
    repeat (2) @(negedge clk_6M);

    // new payload then its duplicate
    rx_pkt("dh1_new", 3'd1, 4'd4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    rx_pkt("dh1_dup", 3'd1, 4'd4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    // bad CRC then POLL leaves ARQN at NAK
    rx_pkt("dh1_badcrc", 3'd2, 4'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    rx_pkt("poll_lt2", 3'd2, TYPE_POLL, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // tx ACK / NAK on lt=3
    tx_pkt(3'd3, 4'd3);
    rx_pkt("ack_lt3", 3'd3, TYPE_POLL, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tx_pkt(3'd3, 4'd3);
    rx_pkt("nak_lt3", 3'd3, TYPE_NULL, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // flush after MAX_RETX NAKs
    tx_pkt(3'd4, 4'd3);
    rx_pkt("nak1_lt4", 3'd4, TYPE_NULL, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    rx_pkt("nak2_lt4", 3'd4, TYPE_NULL, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // slot closes before CRC, buffer full, bad HEC
    rx_pkt("early", 3'd1, 4'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    rx_pkt("buf_full", 3'd5, 4'd10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    rx_pkt("bad_hec", 3'd3, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // FLOW follows buffer state
    rxbuf_full = 1'b1; repeat (8) @(negedge clk_6M);
    chk("flow_full", 8'(rspFLOW), 8'h00);
    rxbuf_full = 1'b0; repeat (8) @(negedge clk_6M);
    chk("flow_free", 8'(rspFLOW), 8'h01);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 1)
        tx_pkt(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      rx_pkt("rand", 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0));
    end

    // reset in the middle of a payload window
    tx_pkt(3'd5, 4'd4);
    rx_pkt("pre_rst", 3'd5, TYPE_POLL, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_strobe();
    rx_trailer_st_p = 1'b1; @(negedge clk_6M); rx_trailer_st_p = 1'b0;
    dec_lt_addr = 3'd6; dec_pk_type = 4'd4; dec_seqn = 1'b1; dec_arqn_bit = 1'b0;
    dec_hecgood = 1'b1; hdr_done_p = 1'b1; @(negedge clk_6M); hdr_done_p = 1'b0;
    @(negedge clk_6M);
    chk("mid.in_py", 8'(fsm_st), 8'(ST_RX_PY));
    a0 = acc_n; d0 = dup_n; k0 = ack_n;
    rstz = 1'b0; #1;
    chk("mid.fsm", 8'(fsm_st), 8'(ST_IDLE));
    chk("mid.txARQN", txARQN, 8'h00);
    chk("mid.txaclSEQN", txaclSEQN, 8'h00);
    chk("mid.tx_retx", tx_retx, 8'h00);
    crc_done_p = 1'b1; crcgood = 1'b1;
    @(negedge clk_6M);
    crc_done_p = 1'b0;
    repeat (2) @(negedge clk_6M);
    rstz = 1'b1;
    model_reset();
    repeat (3) @(negedge clk_6M);
    chk("mid.pulses", 8'(acc_n - a0 + dup_n - d0 + ack_n - k0), 8'h00);
    rx_pkt("post_rst_badhec", 3'd6, 4'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    rx_pkt("post_rst_new", 3'd6, 4'd4, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
